// File: rtl/lag_differentiator_if.sv
// Stream bundle for lag_differentiator.
//   master : drives in_valid / in_data / hold and observes the results
//   slave  : the differentiator itself
// Signals:
//   in_valid  - in_data carries a sample this cycle
//   in_data   - signed input sample x[n]
//   hold      - freeze: no sample accepted, all state retained
//   out_valid - out_data holds a new result this cycle
//   out_data  - signed y[n] = x[n] - x[n-LAG]
//   overflow  - true difference did not fit WORD_SIZE bits
//   primed    - LAG samples accepted since reset
interface lag_differentiator_if #(
  parameter int WORD_SIZE = 8
);
  logic                 in_valid;
  logic [WORD_SIZE-1:0] in_data;
  logic                 hold;
  logic                 out_valid;
  logic [WORD_SIZE-1:0] out_data;
  logic                 overflow;
  logic                 primed;

  modport master (
    output in_valid, in_data, hold,
    input  out_valid, out_data, overflow, primed
  );

  modport slave (
    input  in_valid, in_data, hold,
    output out_valid, out_data, overflow, primed
  );
endinterface

// File: rtl/lag_differentiator.sv
// Lag differentiator: y[n] = x[n] - x[n-LAG] on signed WORD_SIZE samples,
// registered with one cycle of latency. Missing history reads as zero.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - lag_differentiator_if.slave (in_valid, in_data, hold,
//           out_valid, out_data, overflow, primed)
// Build option:
//   LAG_DIFF_SATURATE_EN - when defined, overflowing results clamp to the
//   most positive / most negative value; otherwise they wrap (low bits).
module lag_differentiator #(
  parameter int WORD_SIZE = 8,
  parameter int LAG       = 4
) (
  input logic                  clock,
  input logic                  reset,
  lag_differentiator_if.slave  bus
);
  localparam int             CW      = $clog2(LAG + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(LAG);

  // dly_q[0] is the newest accepted sample, dly_q[LAG-1] the oldest.
  logic [LAG-1:0][WORD_SIZE-1:0] dly_q, dly_d;
  logic [WORD_SIZE-1:0]          out_data_q, out_data_d;
  logic                          ovf_q, ovf_d;
  logic                          vld_q;
  logic [CW-1:0]                 cnt_q, cnt_d;

  logic                 accept;
  logic [WORD_SIZE-1:0] oldest;
  logic [WORD_SIZE:0]   diff;
  logic                 ovf;
  logic [WORD_SIZE-1:0] res;

  always_comb begin
    accept = bus.in_valid & ~bus.hold;
    oldest = dly_q[LAG-1];
    // Sign-extend both operands by one bit so the difference is exact.
    diff   = {bus.in_data[WORD_SIZE-1], bus.in_data} - {oldest[WORD_SIZE-1], oldest};
    // Exact result fits iff the two top bits agree.
    ovf    = diff[WORD_SIZE] ^ diff[WORD_SIZE-1];
`ifdef LAG_DIFF_SATURATE_EN
    if (ovf) res = diff[WORD_SIZE] ? {1'b1, {(WORD_SIZE-1){1'b0}}}
                                   : {1'b0, {(WORD_SIZE-1){1'b1}}};
    else     res = diff[WORD_SIZE-1:0];
`else
    res = diff[WORD_SIZE-1:0];
`endif

    dly_d      = dly_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    if (accept) begin
      dly_d[0] = bus.in_data;
      for (int i = 1; i < LAG; i++) dly_d[i] = dly_q[i-1];
      out_data_d = res;
      ovf_d      = ovf;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dly_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
      vld_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      dly_q      <= dly_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
      vld_q      <= accept;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = ovf_q;
  assign bus.primed    = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_lag_differentiator.sv
module tb_lag_differentiator;
  localparam int W   = 8;
  localparam int LAG = 4;

  logic clock = 1'b0;
  logic reset, reset1;
  always #5 clock = ~clock;

  lag_differentiator_if #(.WORD_SIZE(W)) bus  ();
  lag_differentiator_if #(.WORD_SIZE(W)) bus1 ();

  lag_differentiator #(.WORD_SIZE(W), .LAG(LAG)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));
  lag_differentiator #(.WORD_SIZE(W), .LAG(1)) dut1 (
    .clock(clock), .reset(reset1), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the LAG=4 instance: history queue, exact integer
  // difference, then range check and wrap/clamp.
  int hist[$];
  int exp_out = 0, exp_cnt = 0;
  bit exp_vld = 0, exp_ovf = 0, exp_primed = 0;

  always @(posedge clock) begin
    int x, d, w;
    if (reset) begin
      hist = {};
      for (int i = 0; i < LAG; i++) hist.push_back(0);
      exp_out = 0; exp_vld = 0; exp_ovf = 0; exp_cnt = 0;
    end else if (bus.in_valid && !bus.hold) begin
      x = int'($signed(bus.in_data));
      d = x - hist[0];
      void'(hist.pop_front());
      hist.push_back(x);
      exp_vld = 1;
      exp_ovf = (d > 127) || (d < -128);
`ifdef LAG_DIFF_SATURATE_EN
      w = (d > 127) ? 127 : (d < -128) ? -128 : d;
`else
      w = d & 255;
      if (w > 127) w -= 256;
`endif
      exp_out = w;
      if (exp_cnt < LAG) exp_cnt++;
    end else begin
      exp_vld = 0;
    end
    exp_primed = (exp_cnt == LAG);
  end

  always @(negedge clock) begin
    if (mon_en) begin
      chk("mon_valid",    int'(bus.out_valid), int'(exp_vld));
      chk("mon_data",     int'($signed(bus.out_data)), exp_out);
      chk("mon_overflow", int'(bus.overflow), int'(exp_ovf));
      chk("mon_primed",   int'(bus.primed), int'(exp_primed));
    end
  end

  task automatic step(input logic v, input int d, input logic h, input logic r);
    bus.in_valid = v; bus.in_data = d[W-1:0]; bus.hold = h; reset = r;
    @(posedge clock); #1;
  endtask

  task automatic step1(input logic v, input int d, input logic r);
    bus1.in_valid = v; bus1.in_data = d[W-1:0]; reset1 = r;
    @(posedge clock); #1;
  endtask

  function automatic int sdat();
    return int'($signed(bus.out_data));
  endfunction

  int seq29[6] = '{10, 20, 30, 40, 50, 60};
  int exp29[6] = '{10, 20, 30, 40, 40, 40};

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.hold = 0; reset = 1;
    bus1.in_valid = 0; bus1.in_data = '0; bus1.hold = 0; reset1 = 1;

    // Reset state.
    step(0, 0, 0, 1);
    mon_en = 1'b1;
    chk("rst_data",   sdat(), 0);
    chk("rst_valid",  int'(bus.out_valid), 0);
    chk("rst_ovf",    int'(bus.overflow), 0);
    chk("rst_primed", int'(bus.primed), 0);

    // Basic lag-4 stream.
    for (int i = 0; i < 6; i++) begin
      step(1, seq29[i], 0, 0);
      chk("r29_valid", int'(bus.out_valid), 1);
      chk("r29_data",  sdat(), exp29[i]);
      chk("r29_primed", int'(bus.primed), (i >= 3) ? 1 : 0);
    end
    step(0, 0, 0, 0);
    chk("idle_valid", int'(bus.out_valid), 0);
    chk("idle_keep",  sdat(), 40);

    // hold overrides in_valid.
    step(0, 0, 0, 1);
    step(1, 10, 0, 0); chk("r30_a", sdat(), 10);
    step(1, 20, 0, 0); chk("r30_b", sdat(), 20);
    for (int i = 0; i < 3; i++) begin
      step(1, 99, 1, 0);
      chk("r30_hold_valid", int'(bus.out_valid), 0);
      chk("r30_hold_keep",  sdat(), 20);
    end
    step(1, 30, 0, 0); chk("r30_c", sdat(), 30);
    step(1, 40, 0, 0); chk("r30_d", sdat(), 40);
    step(1, 50, 0, 0); chk("r30_e", sdat(), 40);

    // Positive overflow.
    step(0, 0, 0, 1);
    step(1, -100, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 100, 0, 0);
    chk("r31_ovf", int'(bus.overflow), 1);
`ifdef LAG_DIFF_SATURATE_EN
    chk("r31_data", sdat(), 127);
`else
    chk("r31_data", sdat(), -56);
`endif

    // Negative overflow.
    step(0, 0, 0, 1);
    step(1, 100, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, -100, 0, 0);
    chk("r32_ovf", int'(bus.overflow), 1);
`ifdef LAG_DIFF_SATURATE_EN
    chk("r32_data", sdat(), -128);
`else
    chk("r32_data", sdat(), 56);
`endif
    step(1, -100, 0, 0);
    chk("r32_clear_ovf", int'(bus.overflow), 0);

    // Reset mid-stream wins over a presented sample.
    for (int i = 0; i < 5; i++) step(1, 11 * (i + 1), 0, 0);
    step(1, 77, 0, 1);
    chk("r33_data",   sdat(), 0);
    chk("r33_valid",  int'(bus.out_valid), 0);
    chk("r33_ovf",    int'(bus.overflow), 0);
    chk("r33_primed", int'(bus.primed), 0);
    step(1, 9, 0, 0);
    chk("r33_next",   sdat(), 9);
    chk("r33_next_primed", int'(bus.primed), 0);

    // Randomized traffic, extremes favoured now and then.
    for (int i = 0; i < 600; i++) begin
      int d;
      d = $urandom_range(0, 3) == 0 ? (($urandom_range(0, 1) == 1) ? 127 - $urandom_range(0, 3)
                                                                     : -128 + $urandom_range(0, 3))
                                    : int'($urandom_range(0, 255)) - 128;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0);
    end
    step(0, 0, 0, 0);

    // First-difference instance.
    step1(0, 0, 1);
    step1(1, 3, 0);
    chk("r34_a", int'($signed(bus1.out_data)), 3);
    chk("r34_primed", int'(bus1.primed), 1);
    step1(1, 7, 0);
    chk("r34_b", int'($signed(bus1.out_data)), 4);
    step1(1, 2, 0);
    chk("r34_c", int'($signed(bus1.out_data)), -5);
    chk("r34_valid", int'(bus1.out_valid), 1);
    step1(0, 0, 0);
    chk("r34_idle", int'(bus1.out_valid), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lag_differentiator.md
LAG_DIFFERENTIATOR -- requirements
Module: lag_differentiator

Interface
REQ-001 Parameter WORD_SIZE, default 8, sample width in bits (two's-complement signed), legal 4..32.
REQ-002 Parameter LAG, default 4, difference distance D in samples, legal 1..16.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data carries a sample this cycle.
REQ-006 in_data  input  WORD_SIZE  signed input sample x[n].
REQ-007 hold  input  1  freeze: no sample accepted, all state retained.
REQ-008 out_valid  output  1  out_data holds a new result this cycle.
REQ-009 out_data  output  WORD_SIZE  signed y[n] = x[n] - x[n-LAG].
REQ-010 overflow  output  1  the true difference did not fit WORD_SIZE bits for the current result.
REQ-011 primed  output  1  LAG samples have been accepted since reset.

Function
REQ-012 A sample SHALL be accepted on a rising edge when in_valid=1, hold=0 and reset=0; no other condition accepts.
REQ-013 The block SHALL hold a LAG-entry delay line of past accepted samples, all zero after reset.
REQ-014 On accept, out_data SHALL register in_data minus the oldest delay-line entry, with 1-cycle latency.
REQ-015 On accept, the delay line SHALL shift by one; in_data enters as newest, oldest is discarded.
REQ-016 out_valid SHALL be 1 exactly in the cycle after an accept and 0 otherwise; there is no backpressure.
REQ-017 Without an accept, out_data and overflow SHALL keep their last values.
REQ-018 hold=1 SHALL override in_valid=1: no shift, no output, and prime counter unchanged.
REQ-019 The difference SHALL be computed in WORD_SIZE+1 bits; overflow=1 when the result is outside [-2^(W-1), 2^(W-1)-1].
REQ-020 A prime counter SHALL increment per accept, saturate at LAG, and drive primed=1 when it equals LAG.
REQ-021 Results before primed=1 SHALL still be produced, using zero for missing history (out_data = x[n] for the first LAG accepts).
REQ-022 With LAG=1 the block SHALL behave as a first-difference stage with the same latency and handshake.

Reset
REQ-023 reset=1 SHALL clear the delay line and prime counter, and force out_data=0, out_valid=0, overflow=0 and primed=0 on the same edge.
REQ-024 reset SHALL take priority over in_valid and hold on the same edge; the sample presented with reset is discarded.
REQ-025 Reset mid-stream SHALL discard all history; the next accepted sample is treated as the first after reset.

Configuration
REQ-026 Macro LAG_DIFF_SATURATE_EN defined: on overflow, out_data SHALL clamp to 2^(W-1)-1 (positive) or -2^(W-1) (negative).
REQ-027 Macro LAG_DIFF_SATURATE_EN undefined: out_data SHALL be the low WORD_SIZE bits of the difference (wrap-around).
REQ-028 The overflow flag, latency and handshake SHALL be identical in both builds.

Verification (WORD_SIZE=8, LAG=4 unless stated)
REQ-029 Reset, then accept 10,20,30,40,50,60 -> out_data 10,20,30,40,40,40, each 1 cycle after its accept; primed=1 from the cycle after the 4th accept.
REQ-030 Accept 10,20; assert hold=1 with in_valid=1 for 3 cycles; then accept 30,40,50 -> out_valid=0 during hold; outputs 10,20,30,40,40 (held samples ignored).
REQ-031 Fill with -100,0,0,0, then accept 100 -> overflow=1; out_data=127 with LAG_DIFF_SATURATE_EN, -56 without.
REQ-032 Fill with 100,0,0,0, then accept -100 -> overflow=1; out_data=-128 with macro, 56 without.
REQ-033 Accept 5 samples, assert reset on the same edge as in_valid=1 with in_data=77, then accept 9 -> all outputs 0 and primed=0 after reset; next out_data=9 and primed=0.
REQ-034 LAG=1: accept 3,7,2 -> out_data 3,4,-5; primed=1 after the first accept.
